// File: rtl/div_exec_unit.sv
// Radix-2^BITS_PER_CYCLE restoring divider for DIV/DIVU/REM/REMU. Fixed latency: accept edge + ITERS+2 cycles to done.
// No backpressure: start is only taken in IDLE, requests while busy are dropped; result holds until the next FIX.
module div_exec_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int ITERS = XLEN / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

    generate
        if (XLEN % BITS_PER_CYCLE != 0) begin : g_bad_param
            $error("div_exec_unit: XLEN must be a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic [CW-1:0]   r_cnt;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_dvz;
    logic            r_ovf;

    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_ovf;

    logic [XLEN:0]   w_rem;
    logic [XLEN-1:0] w_quo;

    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_result;

    // Operand conditioning at accept: magnitudes only for the signed ops.
    always_comb begin
        w_signed = ~op[0];
        w_a_neg  = w_signed & dividend[XLEN-1];
        w_b_neg  = w_signed & divisor[XLEN-1];
        w_abs_a  = w_a_neg ? (~dividend + 1'b1) : dividend;
        w_abs_b  = w_b_neg ? (~divisor + 1'b1) : divisor;
        w_ovf    = w_signed
                 & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                 & (divisor == {XLEN{1'b1}});
    end

    // BITS_PER_CYCLE chained restoring steps; the quotient register doubles as
    // the dividend shifter, feeding its MSB into the partial remainder.
    always_comb begin
        w_rem = r_rem;
        w_quo = r_quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_rem = {w_rem[XLEN-1:0], w_quo[XLEN-1]};
            w_quo = {w_quo[XLEN-2:0], 1'b0};
            if (w_rem >= {1'b0, r_dvsr}) begin
                w_rem    = w_rem - {1'b0, r_dvsr};
                w_quo[0] = 1'b1;
            end
        end
    end

    // With a zero divisor every trial subtract succeeds, so the magnitude
    // remainder is |dividend|; restoring its sign reproduces the original dividend.
    always_comb begin
        w_quo_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_rem_fix = r_neg_r ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
        if (r_dvz) begin
            w_quo_fix = {XLEN{1'b1}};
        end else if (r_ovf) begin
            w_quo_fix = {1'b1, {(XLEN-1){1'b0}}};
            w_rem_fix = '0;
        end
        w_result = r_is_rem ? w_rem_fix : w_quo_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dvz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem    <= '0;
                        r_quo    <= w_abs_a;
                        r_dvsr   <= w_abs_b;
                        r_cnt    <= '0;
                        r_is_rem <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_dvz    <= (divisor == '0);
                        r_ovf    <= w_ovf;
                        r_busy   <= 1'b1;
                        r_state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_result;
                    r_done   <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_div_exec_unit.sv
// Directed bench for div_exec_unit: per-cycle busy/done latency, signed/unsigned results,
// divide-by-zero, overflow, start-while-busy and mid-operation reset.
module tb_div_exec_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    div_exec_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        op       = o;
        dividend = a;
        divisor  = b;
    endtask

    // Launch one op and check busy/done every cycle N+1..N+11 and result at N+10.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        drive_start(o, a, b);
        @(posedge clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start    = 1'b0;
            dividend = 32'hDEAD_BEEF;
            divisor  = 32'h0BAD_F00D;
            checks++;
            if (busy !== 1'(k <= 10)) begin
                errors++;
                $display("FAIL %s busy at N+%0d: got %b want %b", name, k, busy, (k <= 10));
            end
            checks++;
            if (done !== 1'(k == 10)) begin
                errors++;
                $display("FAIL %s done at N+%0d: got %b want %b", name, k, done, (k == 10));
            end
            if (k == 10) begin
                checks++;
                if (result !== exp) begin
                    errors++;
                    $display("FAIL %s result: got %h want %h", name, result, exp);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        #2;
        checks++;
        if ({busy, done, result} !== 34'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, result} !== 34'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
    endtask

    task automatic test_basic;
        run_op("div_100_7",  OP_DIV, 32'd100, 32'd7, 32'd14);
        run_op("rem_100_7",  OP_REM, 32'd100, 32'd7, 32'd2);
    endtask

    task automatic test_signs;
        run_op("div_m100_7",   OP_DIV,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2);
        run_op("rem_m100_7",   OP_REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE);
        run_op("rem_100_m7",   OP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2);
        run_op("div_100_m7",   OP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2);
        run_op("divu_max_2",   OP_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF);
        run_op("remu_max_16",  OP_REMU, 32'hFFFF_FFFF, 32'd16,        32'h0000_000F);
        run_op("divu_min_m1",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    endtask

    task automatic test_div_zero;
        run_op("div_5_0",      OP_DIV,  32'd5,         32'd0, 32'hFFFF_FFFF);
        run_op("divu_7_0",     OP_DIVU, 32'd7,         32'd0, 32'hFFFF_FFFF);
        run_op("remu_1234_0",  OP_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234);
        run_op("rem_m5_0",     OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
    endtask

    task automatic test_overflow;
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    endtask

    // Starts at N+3 and N+10 are dropped; the start held in N+11 is taken.
    task automatic test_back_to_back;
        @(negedge clk);
        drive_start(OP_DIV, 32'd100, 32'd7);
        @(posedge clk);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 3 || k == 10 || k == 11) begin
                drive_start(OP_DIVU, 32'd1000, 32'd10);
            end
            checks++;
            if (done !== 1'(k == 10 || k == 21)) begin
                errors++;
                $display("FAIL b2b done at N+%0d: got %b want %b", k, done, (k == 10 || k == 21));
            end
            checks++;
            if (busy !== 1'((k <= 10) || (k >= 12 && k <= 21))) begin
                errors++;
                $display("FAIL b2b busy at N+%0d: got %b", k, busy);
            end
            if (k == 10 || k == 15) begin
                checks++;
                if (result !== 32'd14) begin
                    errors++;
                    $display("FAIL b2b first_result at N+%0d: got %h want %h", k, result, 32'd14);
                end
            end
            if (k == 21) begin
                checks++;
                if (result !== 32'd100) begin
                    errors++;
                    $display("FAIL b2b second_result: got %h want %h", result, 32'd100);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        drive_start(OP_DIV, 32'd100, 32'd7);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result} !== 34'h0) begin
            errors++;
            $display("FAIL abort_async: got busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_no_done cycle %0d: got busy=%b done=%b want 0 0", k, busy, done);
            end
        end
        run_op("after_abort", OP_REMU, 32'd1000, 32'd7, 32'd6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_exec_unit.md
Name: div_exec_unit

Overview:
Multi-cycle integer divider in the execute stage. Executes RISC-V DIV/DIVU/REM/REMU using a radix-2^BITS_PER_CYCLE restoring algorithm. Its fixed latency equals the stall window that the pipeline's divide stall logic holds, so the result is ready exactly when the stall releases. Launched by the same decoded divide-instruction pulse that starts the stall. The result is consumed by the execute-stage result mux.

Parameters:
XLEN, 32, operand and result width.
BITS_PER_CYCLE, 4, quotient bits retired per iteration cycle. XLEN must be divisible by it.
ITERS, XLEN/BITS_PER_CYCLE (derived, localparam), number of iteration cycles. Default is 8.

Ports:
clk  in  1  clock. All state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  launch request. Accepted only in IDLE.
op  in  2  operation select (funct3[1:0]): 00 DIV, 01 DIVU, 10 REM, 11 REMU.
dividend  in  XLEN  rs1 value, sampled on the accept edge.
divisor  in  XLEN  rs2 value, sampled on the accept edge.
busy  out  1  high whenever state is not IDLE.
done  out  1  one-cycle pulse marking result valid.
result  out  XLEN  quotient or remainder, registered.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy 0, done 0, result 0, internal registers 0. Reset mid-operation aborts with no done pulse.
- States: IDLE, ITER, FIX, DONE.
- IDLE, start=1 on an edge:
  - Latch op, operand signs, |dividend|, |divisor| (absolute value only for DIV/REM), zero-divisor flag, and overflow flag (DIV/REM with dividend = 0x8000_0000 and divisor = 0xFFFF_FFFF).
  - Clear partial remainder and iteration counter. Go to ITER.
- ITER: each edge performs BITS_PER_CYCLE chained shift/trial-subtract/restore steps.
  - Partial remainder width is XLEN+1 bits. Quotient bits shift in MSB-first.
  - After ITERS edges go to FIX.
- FIX: one edge. Applies sign correction and special cases, registers result, goes to DONE.
  - Quotient is negated if the operand signs differ (DIV only).
  - Remainder takes the dividend's sign (REM only).
  - Divide by zero: quotient = all ones (DIV and DIVU); remainder = original dividend. Same fixed latency, no early-out.
  - Overflow: quotient = 0x8000_0000, remainder = 0.
- DONE: done=1 for this single cycle, then go to IDLE.
- Latency: start sampled high at the edge ending cycle N gives done=1 in cycle N+ITERS+2 (N+10 at defaults).
  - busy is high in cycles N+1 through N+10. It is low in IDLE only.
- start while busy (any non-IDLE state, including DONE) is ignored with no queuing. The earliest re-accept is the edge ending cycle N+11.
- result holds its value from DONE until the FIX of the next operation. It is not cleared on a new start.
- op, dividend, and divisor are don't-care after the accept edge.

Test Plan:
1. DIV 100/7 and REM 100/7 -> result 14 and 2. done in cycle N+10 exactly; busy high N+1..N+10.
2. DIV -100/7 -> 0xFFFFFFF2 (-14). REM -100/7 -> 0xFFFFFFFE (-2). REM 100/-7 -> 2. DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF. REMU 0xFFFFFFFF/16 -> 0xF.
3. Divisor 0: DIV 5/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. Latency still 10 cycles.
4. Overflow DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
5. start pulsed at N+3 and N+10 with different operands -> ignored, single done at N+10 with the original result. start at N+11 -> accepted, done at N+21.
6. rst_n driven low at N+5 -> busy and done drop to 0 immediately (asynchronously), result 0. No done pulse follows. A new start after release completes normally in 10 cycles.
